// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : opcodes, FSM state encodings and sizing helpers for alu_multicycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Counter must reach WIDTH itself, hence WIDTH+1 codes.
  function automatic int step_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
// ---------------------------------------------------------------------------
// alu_iter_muldiv : one-bit-per-cycle shift-add multiplier / restoring divider
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int            CW   = step_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic             busy_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_fit;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;

  // hi:lo holds partial product (mul) or remainder:dividend/quotient (div).
  always_comb begin
    addend    = lo_q[0] ? opnd_q : '0;
    mul_sum   = {1'b0, hi_q} + {1'b0, addend};
    div_trial = {hi_q, lo_q[WIDTH-1]};
    div_fit   = (div_trial >= {1'b0, opnd_q});
    div_diff  = div_trial[WIDTH-1:0] - opnd_q;
    if (div_q) begin
      hi_step = div_fit ? div_diff : div_trial[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], div_fit};
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign done = busy_q && (cnt_q == LAST);
  assign busy = busy_q;
  assign lo   = lo_q;
  assign hi   = hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      opnd_q <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      div_q  <= is_div;
      cnt_q  <= '0;
      opnd_q <= is_div ? b : a;
      lo_q   <= is_div ? a : b;
      hi_q   <= '0;
    end else if (busy_q) begin
      if (done) begin
        busy_q <= 1'b0;
      end else begin
        hi_q  <= hi_step;
        lo_q  <= lo_step;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle : handshaked ALU, single-cycle logic/arith plus iterative mul/div
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] first_in,
  input  logic [WIDTH-1:0] second_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int M = WIDTH - 1;

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
  logic             c_q, c_d, ov_q, ov_d, z_q, z_d, dbz_q, dbz_d, vld_q, vld_d;

  logic             accept, iter_in;
  logic             md_busy, md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  logic [WIDTH:0]   add_sum, sub_dif;
  logic [WIDTH-1:0] b_neg;
  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_c, sc_ov, sc_dbz;

  assign accept  = (state_q == S_IDLE) && in_valid && in_ready_q;
  // Divide by zero never enters the iterative unit.
  assign iter_in = (operation == OP_MUL) || ((operation == OP_DIV) && (second_in != '0));

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && iter_in),
    .is_div (operation == OP_DIV),
    .a      (first_in),
    .b      (second_in),
    .busy   (md_busy),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  always_comb begin
    add_sum = {1'b0, a_q} + {1'b0, b_q};
    sub_dif = {1'b0, a_q} - {1'b0, b_q};
    b_neg   = ~b_q + WIDTH'(1);
    sc_res  = '0;
    sc_hi   = '0;
    sc_c    = 1'b0;
    sc_ov   = 1'b0;
    sc_dbz  = 1'b0;
    case (op_q)
      OP_SUB: begin
        sc_res = sub_dif[WIDTH-1:0];
        sc_c   = sub_dif[WIDTH];
        sc_ov  = (a_q[M] == b_neg[M]) && (sub_dif[M] != a_q[M]);
      end
      OP_DIV: begin
        sc_res = '1;
        sc_hi  = a_q;
        sc_dbz = 1'b1;
      end
      OP_AND:  sc_res = a_q & b_q;
      OP_OR:   sc_res = a_q | b_q;
      OP_XOR:  sc_res = a_q ^ b_q;
      OP_PASS: sc_res = b_q;
      default: begin
        sc_res = add_sum[WIDTH-1:0];
        sc_c   = add_sum[WIDTH];
        sc_ov  = (a_q[M] == b_q[M]) && (add_sum[M] != a_q[M]);
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    hi_d    = hi_q;
    c_d     = c_q;
    ov_d    = ov_q;
    z_d     = z_q;
    dbz_d   = dbz_q;
    vld_d   = vld_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = operation;
          a_d     = first_in;
          b_d     = second_in;
          state_d = iter_in ? S_ITER : S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = sc_res;
        hi_d    = sc_hi;
        c_d     = sc_c;
        ov_d    = sc_ov;
        z_d     = (sc_res == '0);
        dbz_d   = sc_dbz;
        vld_d   = 1'b1;
        state_d = S_DONE;
      end
      S_ITER: begin
        if (md_done || !md_busy) begin
          res_d   = md_lo;
          hi_d    = md_hi;
          c_d     = 1'b0;
          ov_d    = 1'b0;
          z_d     = (md_lo == '0);
          dbz_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          res_d   = '0;
          hi_d    = '0;
          c_d     = 1'b0;
          ov_d    = 1'b0;
          z_d     = 1'b0;
          dbz_d   = 1'b0;
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      hi_q       <= '0;
      c_q        <= 1'b0;
      ov_q       <= 1'b0;
      z_q        <= 1'b0;
      dbz_q      <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      hi_q       <= hi_d;
      c_q        <= c_d;
      ov_q       <= ov_d;
      z_q        <= z_d;
      dbz_q      <= dbz_d;
      vld_q      <= vld_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = vld_q;
  assign alu_out     = res_q;
  assign alu_out_hi  = hi_q;
  assign carry_out   = c_q;
  assign overflow    = ov_q;
  assign zero        = z_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_alu_multicycle : table vectors, random model ops and handshake/reset corners
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   operation;
  logic [W-1:0] first_in, second_in, alu_out, alu_out_hi;
  logic         carry_out, overflow, zero, div_by_zero;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .operation   (operation),
    .first_in    (first_in),
    .second_in   (second_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_out     (alu_out),
    .alu_out_hi  (alu_out_hi),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c, ov, z, dbz;
    int           lat;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b;
    exp_t         e;
  } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] res, input logic [W-1:0] hi, input logic c,
                              input logic ov, input logic z, input logic dbz, input int lat);
    exp_t e;
    e.res = res; e.hi = hi; e.c = c; e.ov = ov; e.z = z; e.dbz = dbz; e.lat = lat;
    return e;
  endfunction

  // Reference behaviour written from the opcode table using wide native arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]     s;
    logic [2*W-1:0] p;
    logic [W-1:0]   bn;
    exp_t           e;
    e = mk('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    case (op)
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b}; bn = -b;
        e.res = s[W-1:0]; e.c = (a < b);
        e.ov = (a[W-1] == bn[W-1]) && (e.res[W-1] != a[W-1]);
      end
      OP_MUL: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.res = p[W-1:0]; e.hi = p[2*W-1:W]; e.lat = W + 2;
      end
      OP_DIV: begin
        if (b == '0) begin
          e.res = ONES; e.hi = a; e.dbz = 1'b1;
        end else begin
          e.res = a / b; e.hi = a % b; e.lat = W + 2;
        end
      end
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_XOR:  e.res = a ^ b;
      OP_PASS: e.res = b;
      default: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0]; e.c = s[W];
        e.ov = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Waits for in_ready, presents one op for exactly the accepting edge, queues its expectation.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk); n++;
    end
    if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; operation = op; first_in = a; second_in = b;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges with the accepting edge as edge 1, then checks the popped expectation.
  task automatic collect(input string tag);
    int   lat = 1;
    exp_t e;
    while (!out_valid && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".out_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, ".latency"}, 64'(lat), 64'(e.lat));
      chk({tag, ".alu_out"}, alu_out, e.res);
      chk({tag, ".alu_out_hi"}, alu_out_hi, e.hi);
      chk({tag, ".flags(c,ov,z,dbz)"}, {60'd0, carry_out, overflow, zero, div_by_zero},
          {60'd0, e.c, e.ov, e.z, e.dbz});
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".cleared"}, {62'd0, out_valid, (alu_out != '0)}, 64'd0);
    chk({tag, ".in_ready_after"}, {63'd0, in_ready}, 64'd1);
  endtask

  vec_t       vecs[14];
  logic [3:0] ops[9];
  int         acc_t[$];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    operation = '0; first_in = '0; second_in = '0;

    vecs[0]  = '{OP_ADD, ONES, 64'd1, mk(64'd0, '0, 1, 0, 1, 0, 2)};
    vecs[1]  = '{OP_SUB, 64'd5, 64'd7, mk(ONES - 64'd1, '0, 1, 0, 0, 0, 2)};
    vecs[2]  = '{OP_SUB, MSB, 64'd1, mk(~MSB, '0, 0, 1, 0, 0, 2)};
    vecs[3]  = '{OP_MUL, ONES, 64'd2, mk(ONES - 64'd1, 64'd1, 0, 0, 0, 0, 66)};
    vecs[4]  = '{OP_DIV, 64'd100, 64'd7, mk(64'd14, 64'd2, 0, 0, 0, 0, 66)};
    vecs[5]  = '{OP_DIV, 64'd9, 64'd0, mk(ONES, 64'd9, 0, 0, 0, 1, 2)};
    vecs[6]  = '{OP_AND, 64'hF0F0, 64'hFF00, mk(64'hF000, '0, 0, 0, 0, 0, 2)};
    vecs[7]  = '{OP_OR, 64'h0F, 64'hF0, mk(64'hFF, '0, 0, 0, 0, 0, 2)};
    vecs[8]  = '{OP_XOR, 64'hAAAA, 64'hFFFF, mk(64'h5555, '0, 0, 0, 0, 0, 2)};
    vecs[9]  = '{OP_PASS, 64'd123, 64'd0, mk(64'd0, '0, 0, 0, 1, 0, 2)};
    vecs[10] = '{4'hF, 64'd3, 64'd4, mk(64'd7, '0, 0, 0, 0, 0, 2)};
    vecs[11] = '{OP_ADD, ~MSB, 64'd1, mk(MSB, '0, 0, 1, 0, 0, 2)};
    vecs[12] = '{OP_MUL, 64'd0, 64'd5, mk(64'd0, '0, 0, 0, 1, 0, 66)};
    vecs[13] = '{OP_DIV, 64'd5, 64'd9, mk(64'd0, 64'd5, 0, 0, 1, 0, 66)};

    ops = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_PASS, OP_XOR, 4'h5};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst.in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst.outs", {58'd0, out_valid, carry_out, overflow, zero, div_by_zero, (alu_out | alu_out_hi) != '0}, 64'd0);
    rst_n = 1'b1;
    #1 chk("rst.in_ready_before_edge", {63'd0, in_ready}, 64'd0);
    @(posedge clk); @(negedge clk);
    chk("rst.in_ready_after_edge", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
      collect($sformatf("vec%0d", i));
      release_out($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 16; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      op = ops[$urandom_range(0, 8)];
      a  = {$urandom, $urandom};
      b  = (i % 3 == 0) ? 64'($urandom_range(0, 300)) : {$urandom, $urandom};
      issue(op, a, b, model(op, a, b));
      collect($sformatf("rnd%0d", i));
      release_out($sformatf("rnd%0d", i));
    end

    // Consumer stalls for 10 cycles while the source pulses in_valid.
    issue(OP_ADD, 64'd10, 64'd20, mk(64'd30, '0, 0, 0, 0, 0, 2));
    collect("hold");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; operation = OP_SUB; first_in = 64'd1; second_in = 64'd1;
      @(posedge clk); @(negedge clk);
      chk($sformatf("hold%0d.state", i), {62'd0, out_valid, in_ready}, 64'b10);
      chk($sformatf("hold%0d.alu_out", i), alu_out, 64'd30);
    end
    in_valid = 1'b0;
    release_out("hold");
    repeat (3) @(negedge clk);
    chk("hold.not_queued", {63'd0, out_valid}, 64'd0);

    // Back-to-back single-cycle throughput
    out_ready = 1'b1; in_valid = 1'b1; operation = OP_ADD; first_in = 64'd1; second_in = 64'd1;
    for (int t = 0; t < 12; t++) begin
      if (in_valid && in_ready) acc_t.push_back(t);
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    if (acc_t.size() < 3) chk("tput.accepts", 64'(acc_t.size()), 64'd3);
    else begin
      chk("tput.gap1", 64'(acc_t[1] - acc_t[0]), 64'd3);
      chk("tput.gap2", 64'(acc_t[2] - acc_t[1]), 64'd3);
    end

    // Reset dropped in the middle of a multiply
    issue(OP_MUL, ONES, 64'd2, mk(ONES - 64'd1, 64'd1, 0, 0, 0, 0, 66));
    repeat (29) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort.outs", {61'd0, out_valid, in_ready, alu_out != '0}, 64'd0);
    sb.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort.ready", {62'd0, in_ready, out_valid}, 64'b10);
    issue(OP_ADD, 64'd3, 64'd4, mk(64'd7, '0, 0, 0, 0, 0, 2));
    collect("abort.add");
    release_out("abort.add");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
